pe_pragmatic_accum: RTL and testbench
=====================================

// Module: pe_pragmatic_accum
// PURPOSE
//  Downstream consumer of the pragmatic scheduler. Takes per-lane one-offsets and their valid bits.
//  Shifts the latched activations by those offsets and applies the weight sign.
//  Reduces all VEC_LENGTH lanes each cycle and accumulates into one dot-product result.
//  Drives the scheduler's en_comp and detects completion.
//  Presents the result with a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  8   activation width (signed 2's compl.); weight width (sign-magnitude, MSB = sign)
//  VEC_LENGTH  16  number of lanes
//  ACC_WIDTH   24  accumulator/result width, signed
// PORTS
//  clk           in   1                      clock, all state updates on posedge
//  reset         in   1                      synchronous, active-low reset
//  start         in   1                      begin a dot product; sampled only in IDLE
//  acc_keep      in   1                      with start: 1 = keep accumulator, 0 = clear it
//  act           in   DATA_WIDTH x VEC_LENGTH  signed activations, captured on accepted start
//  w_sign        in   VEC_LENGTH             weight sign bits, captured on accepted start (1 = negative)
//  oneffset      in   3 x VEC_LENGTH         per-lane bit position from scheduler
//  val_oneffset  in   VEC_LENGTH             per-lane offset valid from scheduler
//  en_comp       out  1                      scheduler advance enable; registered
//  busy          out  1                      high in any state except IDLE
//  result        out  ACC_WIDTH              accumulated signed dot product
//  result_valid  out  1                      result available
//  out_ready     in   1                      consumer accepts result
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - state=IDLE; en_comp=0, busy=0, result_valid=0, result=0.
//   - Captured act/sign, term counter and primed flag are all cleared.
//   - Applies in any state, including mid-RUN; no partial result is emitted.
//  Scheduler contract
//   - oneffset/val_oneffset are registered in the scheduler on cycles where en_comp=1.
//   - Each input therefore reflects en_comp from the previous edge (1-cycle latency).
//   - Once a lane's bits are exhausted, its val stays 0.
//  FSM: IDLE -> RUN -> DONE -> IDLE
//   - IDLE: on start=1 at edge T:
//     - capture act and w_sign;
//     - accumulator <= acc_keep ? accumulator : 0;
//     - term_cnt<=0, primed<=0;
//     - go to RUN.
//   - RUN: en_comp=1 and busy=1.
//     - First RUN cycle (primed==0): inputs are stale and ignored; primed<=1.
//     - primed==1 and any val_oneffset=1:
//       - acc <= acc + sum(term_j);
//       - term_cnt<=term_cnt+1;
//       - if term_cnt==DATA_WIDTH-2 (7th term consumed), go to DONE on this edge.
//     - primed==1 and all val_oneffset=0: no add; go to DONE.
//   - DONE: en_comp=0, result_valid=1, result=acc held stable.
//     - Leaves to IDLE on the edge where out_ready=1.
//     - result_valid is low the next cycle.
//   - start outside IDLE is ignored (not queued).
//  Arithmetic
//   - term_j = val_j ? (w_sign_j ? -(act_j<<<oneffset_j) : (act_j<<<oneffset_j)) : 0
//   - act_j is sign-extended to ACC_WIDTH before shifting.
//   - Lane terms are summed combinationally.
//   - The accumulator wraps modulo 2^ACC_WIDTH; no saturation and no overflow flag.
//  Latency
//   - With k terms (0<=k<=6), start sampled at edge T gives result_valid high after edge T+3+k.
//   - With k=7, result_valid goes high after edge T+9 (forced DONE).
// TESTING
//  1. Lane0 act=3, sign=0, weight mag 5 (offsets 0,2); other lanes val=0
//     -> result=15, result_valid after T+5.
//  2. All 16 lanes act=-128, sign=1, mag=127 (7 offsets)
//     -> forced DONE after 7 terms, result=+260096, result_valid after T+9.
//  3. All weights zero -> no adds, result=0, result_valid after T+3, en_comp high exactly 2 cycles.
//  4. out_ready low for 5 cycles in DONE, start pulsed meanwhile
//     -> result stable, busy=1, start ignored; IDLE after out_ready=1.
//  5. reset=0 during second RUN term
//     -> next cycle en_comp=0, busy=0, result_valid=0, result=0; later start behaves normally.
//  6. Test 1 followed by start with acc_keep=1 and lane0 act=-2, sign=0, mag 1 -> result=13.

Source files
------------

// File: rtl/pe_pragmatic_accum_if.sv
// Result handshake bundle between the pragmatic accumulator and its consumer.
interface pe_pragmatic_accum_if #(
   parameter int unsigned ACC_WIDTH = 24
) ();
   logic [ACC_WIDTH-1:0] result;
   logic                 result_valid;
   logic                 out_ready;

   modport master (output result, output result_valid, input out_ready);
   modport slave  (input result, input result_valid, output out_ready);
endinterface

// File: rtl/pe_pragmatic_accum.sv
// Pragmatic PE back end: shifts latched activations by scheduler one-offsets,
// applies weight signs, reduces all lanes and accumulates a dot product.
module pe_pragmatic_accum #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned VEC_LENGTH = 16,
   parameter int unsigned ACC_WIDTH  = 24
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 acc_keep,
   input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
   input  logic [VEC_LENGTH-1:0]                w_sign,
   input  logic [VEC_LENGTH-1:0][2:0]           oneffset,
   input  logic [VEC_LENGTH-1:0]                val_oneffset,
   output logic                                 en_comp,
   output logic                                 busy,
   pe_pragmatic_accum_if.master                 res
);

   localparam int unsigned CNT_W     = $clog2(DATA_WIDTH);
   localparam int unsigned LAST_TERM = DATA_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                                state;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
   logic [VEC_LENGTH-1:0]                 sign_q;
   logic signed [ACC_WIDTH-1:0]           acc;
   logic [CNT_W-1:0]                      term_cnt;
   logic                                  primed;
   logic                                  result_valid_q;

   logic signed [ACC_WIDTH-1:0]           term [VEC_LENGTH];
   logic signed [ACC_WIDTH-1:0]           lane_sum;

   // Per-lane signed shifted terms, reduced across all lanes in one cycle.
   always_comb begin
      lane_sum = '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
         term[j] = ACC_WIDTH'($signed(act_q[j])) <<< oneffset[j];
         if (sign_q[j])
            term[j] = -term[j];
         if (!val_oneffset[j])
            term[j] = '0;
         lane_sum = lane_sum + term[j];
      end
   end

   // Control FSM; the first RUN cycle only primes the scheduler pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         en_comp        <= 1'b0;
         busy           <= 1'b0;
         result_valid_q <= 1'b0;
         acc            <= '0;
         act_q          <= '0;
         sign_q         <= '0;
         term_cnt       <= '0;
         primed         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               result_valid_q <= 1'b0;
               if (start) begin
                  act_q    <= act;
                  sign_q   <= w_sign;
                  if (!acc_keep)
                     acc <= '0;
                  term_cnt <= '0;
                  primed   <= 1'b0;
                  en_comp  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (!primed) begin
                  primed <= 1'b1;
               end else if (|val_oneffset) begin
                  acc      <= acc + lane_sum;
                  term_cnt <= term_cnt + CNT_W'(1);
                  // A sign-magnitude weight has at most DATA_WIDTH-1 one-bits.
                  if (term_cnt == CNT_W'(LAST_TERM)) begin
                     en_comp <= 1'b0;
                     state   <= DONE;
                  end
               end else begin
                  en_comp <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (!result_valid_q) begin
                  result_valid_q <= 1'b1;
               end else if (res.out_ready) begin
                  result_valid_q <= 1'b0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               en_comp        <= 1'b0;
               busy           <= 1'b0;
               result_valid_q <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

   assign res.result       = acc;
   assign res.result_valid = result_valid_q;

endmodule

// File: tb/tb_pe_pragmatic_accum.sv
// Directed bench for pe_pragmatic_accum with a behavioural scheduler and a
// scoreboard of expected result/latency/en_comp-count per dot product.
module tb_pe_pragmatic_accum;

   localparam int unsigned DW = 8;
   localparam int unsigned VL = 16;
   localparam int unsigned AW = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset;
   logic                 start;
   logic                 acc_keep;
   logic [VL-1:0][DW-1:0] act;
   logic [VL-1:0]        w_sign;
   logic [VL-1:0][2:0]   oneffset;
   logic [VL-1:0]        val_oneffset;
   logic                 en_comp;
   logic                 busy;

   pe_pragmatic_accum_if #(.ACC_WIDTH(AW)) res_if ();

   pe_pragmatic_accum #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .acc_keep     (acc_keep),
      .act          (act),
      .w_sign       (w_sign),
      .oneffset     (oneffset),
      .val_oneffset (val_oneffset),
      .en_comp      (en_comp),
      .busy         (busy),
      .res          (res_if)
   );

   typedef struct {
      longint res;
      int     lat;
      int     en;
   } exp_t;

   exp_t   exp_q[$];
   int     wmag[VL];
   int     idx[VL];
   int     checks = 0;
   int     fails  = 0;
   longint acc_model = 0;
   longint last_res  = 0;
   logic signed [AW-1:0] r;

   function automatic int popcnt(int m);
      int c = 0;
      for (int b = 0; b < int'(DW) - 1; b++) if (m[b]) c++;
      return c;
   endfunction

   function automatic int nth_bit(int m, int n);
      int c = 0;
      for (int b = 0; b < int'(DW) - 1; b++) begin
         if (m[b]) begin
            if (c == n) return b;
            c++;
         end
      end
      return 0;
   endfunction

   // Scheduler model: emits one one-offset per lane per en_comp cycle, LSB first.
   always @(posedge clk) begin
      if (!reset) begin
         for (int j = 0; j < int'(VL); j++) idx[j] <= 0;
         val_oneffset <= '0;
         oneffset     <= '0;
      end else if (start && !busy) begin
         for (int j = 0; j < int'(VL); j++) idx[j] <= 0;
      end else if (en_comp) begin
         for (int j = 0; j < int'(VL); j++) begin
            if (idx[j] < popcnt(wmag[j])) begin
               oneffset[j]     <= 3'(nth_bit(wmag[j], idx[j]));
               val_oneffset[j] <= 1'b1;
               idx[j]          <= idx[j] + 1;
            end else begin
               val_oneffset[j] <= 1'b0;
            end
         end
      end
   end

   task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_all(int a, bit s, int m);
      for (int j = 0; j < int'(VL); j++) begin
         act[j]    = DW'(a);
         w_sign[j] = s;
         wmag[j]   = m;
      end
   endtask

   task automatic set_lane0_only(int a, bit s, int m);
      for (int j = 0; j < int'(VL); j++) begin
         act[j]    = DW'($urandom);
         w_sign[j] = 1'($urandom);
         wmag[j]   = 0;
      end
      act[0]    = DW'(a);
      w_sign[0] = s;
      wmag[0]   = m;
   endtask

   // Push the expectation, then pulse start; returns 1 time unit after edge T.
   task automatic launch(bit keep);
      exp_t e;
      longint dot = 0;
      int k = 0;
      logic signed [AW-1:0] w;
      logic signed [DW-1:0] a;
      for (int j = 0; j < int'(VL); j++) begin
         a = act[j];
         dot += w_sign[j] ? -(longint'(a) * wmag[j]) : longint'(a) * wmag[j];
         if (popcnt(wmag[j]) > k) k = popcnt(wmag[j]);
      end
      acc_model = keep ? acc_model + dot : dot;
      w = AW'(acc_model);
      acc_model = w;
      e.res = acc_model;
      e.lat = (k == int'(DW) - 1) ? 9 : 3 + k;
      e.en  = (k == int'(DW) - 1) ? 8 : 2 + k;
      exp_q.push_back(e);
      start    = 1'b1;
      acc_keep = keep;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic collect(string tag);
      exp_t e;
      int n = 0;
      int en_cnt = 0;
      en_cnt = int'(en_comp);
      while (!res_if.result_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         en_cnt += int'(en_comp);
      end
      check({tag, " valid_seen"}, 64'(res_if.result_valid), 64'(1));
      if (exp_q.size() == 0) begin
         check({tag, " sb_nonempty"}, 64'(0), 64'(1));
      end else begin
         e = exp_q.pop_front();
         r = res_if.result;
         check({tag, " result"}, r, e.res);
         check({tag, " latency"}, n, e.lat);
         check({tag, " en_cycles"}, en_cnt, e.en);
         last_res = e.res;
      end
   endtask

   task automatic accept(string tag);
      res_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      res_if.out_ready = 1'b0;
      check({tag, " valid_drop"}, 64'(res_if.result_valid), 64'(0));
      check({tag, " busy_drop"}, 64'(busy), 64'(0));
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      acc_keep = 1'b0;
      res_if.out_ready = 1'b0;
      set_all(0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      r = res_if.result;
      check("rst en_comp", 64'(en_comp), 64'(0));
      check("rst busy", 64'(busy), 64'(0));
      check("rst valid", 64'(res_if.result_valid), 64'(0));
      check("rst result", r, 64'(0));
      reset = 1'b1;
      @(posedge clk);
      #1;

      // lane0 3 * +5
      set_lane0_only(3, 1'b0, 5);
      launch(1'b0);
      collect("t1");
      accept("t1");

      // keep accumulator: 15 + (-2 * 1)
      set_lane0_only(-2, 1'b0, 1);
      launch(1'b1);
      collect("t6");
      accept("t6");

      // all lanes -128 * -127, forced DONE after seven terms
      set_all(-128, 1'b1, 127);
      launch(1'b0);
      collect("t2");
      accept("t2");

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < int'(VL); j++) begin
            act[j]    = DW'($urandom);
            w_sign[j] = 1'($urandom);
            wmag[j]   = int'($urandom_range(0, 127));
         end
         launch(1'($urandom));
         collect("rand");
         accept("rand");
      end

      // all weights zero, then hold the result in DONE with start pulsed
      for (int j = 0; j < int'(VL); j++) begin
         act[j]    = DW'($urandom);
         w_sign[j] = 1'($urandom);
         wmag[j]   = 0;
      end
      launch(1'b0);
      collect("t3");
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         set_all(5, 1'b0, 3);
         @(posedge clk);
         #1;
         start = 1'b0;
         r = res_if.result;
         check("t4 hold_result", r, last_res);
         check("t4 hold_busy", 64'(busy), 64'(1));
         check("t4 hold_valid", 64'(res_if.result_valid), 64'(1));
         check("t4 hold_en", 64'(en_comp), 64'(0));
      end
      accept("t4");
      repeat (3) begin
         @(posedge clk);
         #1;
         check("t4 idle_busy", 64'(busy), 64'(0));
         check("t4 idle_en", 64'(en_comp), 64'(0));
      end
      check("t4 sb_empty", 64'(exp_q.size()), 64'(0));

      // reset asserted on the edge that consumes the second term
      set_lane0_only(3, 1'b0, 5);
      launch(1'b0);
      void'(exp_q.pop_back());
      acc_model = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      r = res_if.result;
      check("t5 en_comp", 64'(en_comp), 64'(0));
      check("t5 busy", 64'(busy), 64'(0));
      check("t5 valid", 64'(res_if.result_valid), 64'(0));
      check("t5 result", r, 64'(0));
      reset = 1'b1;
      @(posedge clk);
      #1;
      set_lane0_only(3, 1'b0, 5);
      launch(1'b0);
      collect("t5 after");
      accept("t5 after");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
